// File: rtl/div_pkg.sv
// Shared widths, iteration bound and FSM state type for the 12-by-6 restoring divider.
package div_pkg;

  localparam int DVD_W = 12;
  localparam int DVS_W = 6;
  localparam int CNT_W = 4;

  // Counter value at which the final quotient bit is produced.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_12by6_div_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract the
// divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [DVS_W-1:0] rem,
  input  logic             dvd_msb,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] next_rem,
  output logic             q_bit
);

  logic [DVS_W:0] t;
  logic [DVS_W:0] diff;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    t        = {rem, dvd_msb};
    diff     = t - {1'b0, divisor};
    q_bit    = (t >= {1'b0, divisor});
    next_rem = q_bit ? diff[DVS_W-1:0] : t[DVS_W-1:0];
  end

endmodule

// File: rtl/divider_12by6.sv
// 12-bit by 6-bit unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit a zero divisor and flag it.
module divider_12by6
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] quotient_q;
  logic [DVS_W-1:0] remainder_q;
  logic [DVS_W-1:0] next_rem;
  logic             q_bit;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic             dbz_q;
`endif

  div_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DVD_W-1]),
    .divisor  (dvs),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
`ifdef DIVIDER_ZERO_DETECT_EN
            dbz_q <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef DIVIDER_ZERO_DETECT_EN
          if (dvs == '0) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            dbz_q       <= 1'b1;
            state       <= DONE;
          end else
`endif
          begin
            dvd <= {dvd[DVD_W-2:0], q_bit};
            rem <= next_rem;
            cnt <= cnt + CNT_W'(1);
            // Results are published on the same edge as the final iteration.
            if (cnt == LAST_ITER) begin
              quotient_q  <= {dvd[DVD_W-2:0], q_bit};
              remainder_q <= next_rem;
              state       <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_12by6.sv
// Self-checking bench for divider_12by6: directed corner cases plus random
// operands checked against plain integer division.
module tb_divider_12by6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [11:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic        ready, busy, done, div_by_zero;
  logic [11:0] quotient;
  logic [5:0]  remainder;

  int total = 0;
  int bad   = 0;

  divider_12by6 dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present operands, let the accepting edge pass, then scramble the inputs.
  task automatic start_div(input logic [11:0] a, input logic [5:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 12'($urandom);
    divisor  = 6'($urandom);
  endtask

  // Edges from the accepting edge to the first edge showing done; 99 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (lat > 40) begin
        lat = 99;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [11:0] a, input logic [5:0] b);
    int lat;
    int exp_lat, exp_q, exp_r, exp_z;
    if (b != 0) begin
      exp_lat = 12; exp_q = a / b; exp_r = a % b; exp_z = 0;
    end else begin
`ifdef DIVIDER_ZERO_DETECT_EN
      exp_lat = 1;  exp_q = 12'hFFF; exp_r = 0; exp_z = 1;
`else
      exp_lat = 12; exp_q = 12'hFFF; exp_r = a % 64; exp_z = 0;
`endif
    end
    check({tag, ".ready"}, ready, 1);
    start_div(a, b);
    wait_done(lat);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".quotient"}, quotient, exp_q);
    check({tag, ".remainder"}, remainder, exp_r);
    check({tag, ".dbz"}, div_by_zero, exp_z);
    @(posedge clk);
    #1;
    check({tag, ".done_fall"}, done, 0);
    check({tag, ".ready_after"}, ready, 1);
  endtask

  initial begin
    int ndone, done_at;
    logic [11:0] q_seen;
    logic [5:0]  r_seen;
    logic [11:0] a;
    logic [5:0]  b;
    int lat;

    #12;
    check("rst.ready", ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.dbz", div_by_zero, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_check("d100_7", 12'd100, 6'd7);
    run_check("d4095_63", 12'd4095, 6'd63);
    run_check("d5_9", 12'd5, 6'd9);
    run_check("dabc_0", 12'hABC, 6'd0);
    run_check("d77_5", 12'd77, 6'd5);

    // A second start with different operands during RUN must be ignored.
    start_div(12'd100, 6'd7);
    check("ign.busy", busy, 1);
    ndone = 0; done_at = -1; q_seen = '0; r_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start    = (i == 3);
      dividend = 12'd50;
      divisor  = 6'd3;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = i + 1;
          q_seen  = quotient;
          r_seen  = remainder;
        end
      end
    end
    start = 1'b0;
    check("ign.pulses", ndone, 1);
    check("ign.latency", done_at, 12);
    check("ign.quotient", q_seen, 14);
    check("ign.remainder", r_seen, 2);
    check("ign.hold_q", quotient, 14);
    check("ign.hold_r", remainder, 2);

    // Reset in the middle of a division, with start held high during reset.
    start_div(12'd1000, 6'd3);
    repeat (6) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mid.ready", ready, 1);
    check("mid.busy", busy, 0);
    check("mid.done", done, 0);
    check("mid.quotient", quotient, 0);
    check("mid.remainder", remainder, 0);
    check("mid.dbz", div_by_zero, 0);
    start = 1'b1;
    dividend = 12'd999;
    divisor  = 6'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rstn  = 1'b1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("mid.no_done", ndone, 0);
    check("mid.idle", ready, 1);
    run_check("d1000_3", 12'd1000, 6'd3);

    for (int n = 0; n < 2000; n++) begin
      a = 12'($urandom);
      b = 6'($urandom_range(63, 1));
      start_div(a, b);
      wait_done(lat);
      check("rnd.latency", lat, 12);
      check("rnd.identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("rnd.rem_lt", (remainder < b), 1);
      check("rnd.quotient", quotient, a / b);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
